// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the core load/store path (c_*)
// and an external loader/DMA port (e_*). One access per cycle, granted
// combinationally in the request cycle. Arbitration is round-robin; the
// external port may hold ownership for up to BURST_MAX consecutive cycles by
// keeping e_lock high, after which a pending core request is forced through.
//
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata and holds them
// until x_gnt is seen high in the same cycle; the access happens in that
// cycle. Reads return x_rdata with x_rvalid high for one cycle on the next
// cycle. Dropping x_req before a grant is legal and causes no access.
//
// Ports:
//   clk, areset (async, active low)
//   c_req/c_we/c_addr/c_wdata  -> c_gnt, c_stall, c_rvalid, c_rdata
//   e_req/e_we/e_lock/e_addr/e_wdata -> e_gnt, e_rvalid, e_rdata
//   m_we/m_addr/m_wdata -> memory, m_rdata <- memory (combinational)
//   conflict_cnt, stall_max (only with DMEM_ARB_STATS_EN defined)
//
// Optional feature macro: DMEM_ARB_STATS_EN adds conflict and stall counters.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          e_req,
    input  logic          e_we,
    input  logic          e_lock,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    output logic          e_gnt,
    output logic          e_rvalid,
    output logic [DW-1:0] e_rdata,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   stall_max
`endif
);

    localparam logic [7:0] BM8 = 8'(BURST_MAX);

    logic          r_prio;       // 0: core favoured, 1: external favoured
    logic [7:0]    r_burst_cnt;
    logic          r_e_locked;
    logic          r_c_rvalid;
    logic          r_e_rvalid;
    logic [DW-1:0] r_c_rdata;
    logic [DW-1:0] r_e_rdata;

    // Arbitration result before reset gating. State updates use these
    // directly; reset overrides the flops anyway, and only the outputs
    // need to be forced quiet while areset is low.
    logic w_c_arb;
    logic w_e_arb;
    logic w_force_yield;

    assign w_force_yield = r_e_locked & e_lock & (r_burst_cnt >= BM8);

    always_comb begin
        w_c_arb = 1'b0;
        w_e_arb = 1'b0;
        if (r_e_locked && e_req && e_lock && !(w_force_yield && c_req)) begin
            w_e_arb = 1'b1;
        end else if (c_req && e_req) begin
            // An exhausted burst hands the port to the core regardless of prio.
            if (w_force_yield || !r_prio) w_c_arb = 1'b1;
            else                          w_e_arb = 1'b1;
        end else if (c_req) begin
            w_c_arb = 1'b1;
        end else if (e_req) begin
            w_e_arb = 1'b1;
        end
    end

    assign c_gnt   = w_c_arb & areset;
    assign e_gnt   = w_e_arb & areset;
    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (e_gnt) begin
            m_we    = e_we;
            m_addr  = e_addr;
            m_wdata = e_wdata;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_prio      <= 1'b0;
            r_burst_cnt <= 8'd0;
            r_e_locked  <= 1'b0;
            r_c_rvalid  <= 1'b0;
            r_e_rvalid  <= 1'b0;
            r_c_rdata   <= '0;
            r_e_rdata   <= '0;
        end else begin
            if (w_c_arb)      r_prio <= 1'b1;
            else if (w_e_arb) r_prio <= 1'b0;

            if (w_e_arb && e_lock)
                r_burst_cnt <= (r_burst_cnt >= BM8) ? BM8 : r_burst_cnt + 8'd1;
            else
                r_burst_cnt <= 8'd0;

            r_e_locked <= w_e_arb & e_lock;

            r_c_rvalid <= w_c_arb & ~c_we;
            r_e_rvalid <= w_e_arb & ~e_we;
            if (w_c_arb && !c_we) r_c_rdata <= m_rdata;
            if (w_e_arb && !e_we) r_e_rdata <= m_rdata;
        end
    end

    assign c_rvalid = r_c_rvalid;
    assign e_rvalid = r_e_rvalid;
    assign c_rdata  = r_c_rdata;
    assign e_rdata  = r_e_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [15:0] r_stall_run;
    logic [15:0] r_stall_max;
    logic        w_stall_arb;

    assign w_stall_arb = c_req & ~w_c_arb;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_conflict_cnt <= 16'd0;
            r_stall_run    <= 16'd0;
            r_stall_max    <= 16'd0;
        end else begin
            if (c_req && e_req && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;

            if (w_stall_arb) begin
                if (r_stall_run != 16'hFFFF) begin
                    r_stall_run <= r_stall_run + 16'd1;
                    // Current run length including this cycle.
                    if (r_stall_run + 16'd1 > r_stall_max)
                        r_stall_max <= r_stall_run + 16'd1;
                end
            end else begin
                r_stall_run <= 16'd0;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign stall_max    = r_stall_max;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 8;
    localparam int GW = 4 + AW + DW;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt, c_stall, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          e_req = 1'b0, e_we = 1'b0, e_lock = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .areset(areset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    logic [DW-1:0] mem [256];
    assign m_rdata = mem[m_addr[7:0]];
    always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_ref [256];
    bit            prio_m   = 1'b0;   // 1: external side favoured
    int            burst_m  = 0;
    bit            locked_m = 1'b0;
    bit            pend_c_v = 1'b0, pend_e_v = 1'b0;
    logic [DW-1:0] pend_c, pend_e;

    logic [GW-1:0] exp_q[$];
    logic [DW-1:0] exp_c_q[$];
    logic [DW-1:0] exp_e_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic drive(input bit rst_n,
                         input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit er, input bit ew, input bit el, input logic [AW-1:0] ea,
                         input logic [DW-1:0] ed);
        bit gc, ge, force_c, mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwd;
        @(posedge clk);
        #1;
        // Reads granted last cycle surface now unless reset kills them.
        if (pend_c_v && rst_n) exp_c_q.push_back(pend_c);
        if (pend_e_v && rst_n) exp_e_q.push_back(pend_e);
        pend_c_v = 1'b0;
        pend_e_v = 1'b0;

        areset = rst_n;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        e_req = er; e_we = ew; e_lock = el; e_addr = ea; e_wdata = ed;

        gc = 1'b0;
        ge = 1'b0;
        if (rst_n) begin
            force_c = locked_m && el && er && cr && (burst_m >= BM);
            if (locked_m && el && er && !force_c) ge = 1'b1;
            else if (cr && er) begin
                if (force_c || !prio_m) gc = 1'b1;
                else                    ge = 1'b1;
            end
            else if (cr) gc = 1'b1;
            else if (er) ge = 1'b1;
        end

        mwe = 1'b0; maddr = '0; mwd = '0;
        if (gc) begin mwe = cw; maddr = ca; mwd = cd; end
        if (ge) begin mwe = ew; maddr = ea; mwd = ed; end
        exp_q.push_back({gc, ge, cr & ~gc, mwe, maddr, mwd});

        if (gc && !cw) begin pend_c_v = 1'b1; pend_c = mem_ref[ca[7:0]]; end
        if (ge && !ew) begin pend_e_v = 1'b1; pend_e = mem_ref[ea[7:0]]; end
        if (gc && cw) mem_ref[ca[7:0]] = cd;
        if (ge && ew) mem_ref[ea[7:0]] = ed;

        if (!rst_n) begin
            prio_m = 1'b0; burst_m = 0; locked_m = 1'b0;
        end else begin
            if (gc) prio_m = 1'b1;
            else if (ge) prio_m = 1'b0;
            if (ge && el) burst_m = (burst_m >= BM) ? BM : burst_m + 1;
            else          burst_m = 0;
            locked_m = ge && el;
        end
    endtask

    task automatic idle(input bit rst_n);
        drive(rst_n, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [GW-1:0] got, exp;
        logic [DW-1:0] last_c, last_e, x;
        last_c = '0;
        last_e = '0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {c_gnt, e_gnt, c_stall, m_we, m_addr, m_wdata};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL grant_mux t=%0t got gc=%b ge=%b st=%b we=%b a=%h d=%h exp gc=%b ge=%b st=%b we=%b a=%h d=%h",
                             $time, got[GW-1], got[GW-2], got[GW-3], got[GW-4], got[AW+DW-1:DW], got[DW-1:0],
                             exp[GW-1], exp[GW-2], exp[GW-3], exp[GW-4], exp[AW+DW-1:DW], exp[DW-1:0]);
                end
            end
            if (!areset) begin last_c = '0; last_e = '0; end

            n_tests++;
            if (c_rvalid !== (exp_c_q.size() > 0)) begin
                n_fail++;
                $display("FAIL c_rvalid t=%0t got %b exp %b", $time, c_rvalid, exp_c_q.size() > 0);
                exp_c_q.delete();
            end else if (c_rvalid) begin
                x = exp_c_q.pop_front();
                last_c = x;
            end
            n_tests++;
            if (c_rdata !== last_c) begin
                n_fail++;
                $display("FAIL c_rdata t=%0t got %h exp %h", $time, c_rdata, last_c);
            end

            n_tests++;
            if (e_rvalid !== (exp_e_q.size() > 0)) begin
                n_fail++;
                $display("FAIL e_rvalid t=%0t got %b exp %b", $time, e_rvalid, exp_e_q.size() > 0);
                exp_e_q.delete();
            end else if (e_rvalid) begin
                x = exp_e_q.pop_front();
                last_e = x;
            end
            n_tests++;
            if (e_rdata !== last_e) begin
                n_fail++;
                $display("FAIL e_rdata t=%0t got %h exp %h", $time, e_rdata, last_e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            mem_ref[i] = mem[i];
        end
        mem[8'h10] = 32'hDEADBEEF;
        mem_ref[8'h10] = 32'hDEADBEEF;

        // Reset state.
        repeat (3) idle(1'b0);

        // Single core load.
        drive(1, 1, 0, 32'h10, '0, 0, 0, 0, '0, '0);
        repeat (2) idle(1'b1);

        // Fresh reset, then plain conflict for 4 cycles: c,e,c,e.
        idle(1'b0);
        repeat (4) drive(1, 1, 0, 32'h30, '0, 1, 0, 0, 32'h40, '0);
        idle(1'b1);

        // Locked burst against a waiting core.
        idle(1'b0);
        repeat (12) drive(1, 1, 0, 32'h31, '0, 1, 0, 1, 32'h41, '0);
        idle(1'b1);

        // Locked burst with no competition, 20 cycles, mixed reads/writes.
        for (int i = 0; i < 20; i++)
            drive(1, 0, 0, '0, '0, 1, 1'($urandom_range(0, 1)), 1,
                  32'($urandom_range(0, 255)), $urandom);
        idle(1'b1);

        // Same-cycle store vs load at one address: store goes first.
        idle(1'b0);
        drive(1, 1, 1, 32'h20, 32'h55, 1, 0, 0, 32'h20, '0);
        drive(1, 0, 0, '0, '0, 1, 0, 0, 32'h20, '0);
        repeat (2) idle(1'b1);

        // Reset in the middle of a locked external write burst.
        repeat (5) drive(1, 1, 1, 32'h50, 32'h1111, 1, 1, 1, 32'h60, 32'hABCD);
        repeat (2) drive(0, 1, 1, 32'h50, 32'h1111, 1, 1, 1, 32'h60, 32'hABCD);
        repeat (3) drive(1, 1, 0, 32'h50, '0, 1, 0, 0, 32'h60, '0);
        idle(1'b1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) != 0),
                  32'($urandom_range(0, 255)), $urandom);
        end

        repeat (3) idle(1'b1);
        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0 || exp_c_q.size() != 0 || exp_e_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d/%0d/%0d pending exp 0/0/0",
                     exp_q.size(), exp_c_q.size(), exp_e_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core's load/store path (port c_) and an external loader/DMA port (port e_).
- At most one memory access is issued per cycle.
- Arbitration is round-robin, with an optional locked burst on the external port.
- Sits between the core datapath and the data memory. Drives a stall to the core so the PC and register write are held while the core waits for a grant.

Parameters:
AW, 32, address width (bits)
DW, 32, data width (bits)
BURST_MAX, 8, max consecutive locked grants to e_ before a forced yield to a pending c_ request (range 1..255)

Ports:
clk  input  1  clock, all state on rising edge
areset  input  1  asynchronous active-low reset
c_req  input  1  core access request
c_we  input  1  core write enable (1=store, 0=load)
c_addr  input  AW  core address
c_wdata  input  DW  core store data
c_gnt  output  1  core access issued this cycle
c_stall  output  1  c_req & ~c_gnt
c_rvalid  output  1  core load data valid
c_rdata  output  DW  core load data
e_req  input  1  external request
e_we  input  1  external write enable
e_lock  input  1  request to keep ownership on following cycles
e_addr  input  AW  external address
e_wdata  input  DW  external write data
e_gnt  output  1  external access issued this cycle
e_rvalid  output  1  external read data valid
e_rdata  output  DW  external read data
m_we  output  1  memory write enable
m_addr  output  AW  memory address
m_wdata  output  DW  memory write data
m_rdata  input  DW  memory read data (combinational from m_addr)

Behaviour:
- State: prio (0=core favoured, 1=ext favoured), burst_cnt [7:0], e_locked (ext granted with e_lock=1 last cycle), two rvalid flags, two rdata registers.
- Reset (areset low, asynchronous): prio=0, burst_cnt=0, e_locked=0, c_rvalid=e_rvalid=0, c_rdata=e_rdata=0.
- While areset is low: c_gnt=e_gnt=0, m_we=0, m_addr=0, m_wdata=0. No memory write occurs.
- Grant is combinational, in the same cycle as the request. Exactly one of the following applies:
  1. e_locked & e_req & e_lock & burst_cnt<BURST_MAX -> e_gnt.
  2. Only one requester active -> grant it.
  3. Both active -> grant c_ if prio=0, e_ if prio=1.
- Rule 1 does not apply if burst_cnt==BURST_MAX and c_req=1. In that case the core is granted, regardless of prio.
- If burst_cnt==BURST_MAX and c_req=0, e_ keeps the grant and burst_cnt saturates.
- After any grant, prio becomes the opposite of the granted side. prio is unchanged when nothing is granted.
- burst_cnt: +1 (saturating at BURST_MAX) on each e_gnt with e_lock=1; cleared on any cycle without e_gnt, or with e_gnt and e_lock=0.
- e_locked <= e_gnt & e_lock.
- Memory mux:
  - The granted side drives m_we/m_addr/m_wdata.
  - With no grant: m_we=0, and m_addr/m_wdata are 0.
  - A write commits at the memory on the rising edge ending the grant cycle.
- Read return: one cycle of latency.
  - On a grant with we=0, the edge loads x_rdata<=m_rdata and sets x_rvalid=1 for exactly one cycle.
  - rdata holds its value until the next read for that side.
  - A write grant returns no rvalid.
- Requesters hold req/we/addr/wdata stable until gnt. A request dropped before gnt is legal and causes no access.
- Back-to-back grants to the same side are allowed: reads in consecutive cycles yield rvalid in consecutive cycles.
- A reset asserted mid-burst clears the lock. After release, the first conflict is won by the core.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds output port conflict_cnt [15:0], which counts cycles with c_req & e_req, saturating at 16'hFFFF.
  - Adds output port stall_max [15:0], the longest run of consecutive c_stall cycles seen.
  - Both are cleared by reset.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then c_req load, addr=0x10, mem[0x10]=0xDEADBEEF -> c_gnt=1 same cycle, c_rvalid=1 next cycle with c_rdata=0xDEADBEEF, c_stall=0.
- c_req and e_req both held, no lock, 4 cycles -> grants alternate c,e,c,e; c_stall high on cycles 2 and 4.
- e_lock=1 with both requesting, BURST_MAX=8 -> after e_ wins a cycle, e_ granted 8 consecutive cycles, then c_gnt=1 on the 9th.
- e_lock=1, c_req=0 for 20 cycles -> e_gnt held all 20 cycles, burst_cnt stays at 8, m_we follows e_we.
- Same-cycle c_ store 0x55 to 0x20 vs e_ load of 0x20 with prio=0 -> store commits first; e_ load next cycle returns 0x55.
- areset asserted mid-burst during an e_ write -> m_we=0 immediately, rvalids=0; after release, first conflict grants the core.
